// File: rtl/grayscale_stream_pkg.sv
// Shared frame geometry and types for the grayscale and Sobel edge stages.
package grayscale_stream_pkg;

    localparam int FRAME_WIDTH  = 720;
    localparam int FRAME_HEIGHT = 540;
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int CNT_WIDTH    = 19;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [9:0] rgb_sum(input rgb_t p);
        return {2'b00, p.r} + {2'b00, p.g} + {2'b00, p.b};
    endfunction

endpackage

// File: rtl/grayscale_stream_gray_div3.sv
// Combinational floor(sum/3) for sums 0..765, kept separate so it can be checked exhaustively.
module gray_div3 (
    input  logic [9:0] sum,
    output logic [7:0] quot
);
    // 683/2048 overshoots 1/3 by sum/6144, which never crosses an integer boundary below 766.
    assign quot = 8'((20'(sum) * 20'd683) >> 11);

endmodule

// File: rtl/grayscale_stream.sv
// One-frame RGB to grayscale converter between an FWFT input FIFO and the edge stage's FIFO.
module grayscale_stream #(
    parameter int FRAME_PIXELS = grayscale_stream_pkg::FRAME_PIXELS,
    parameter int CNT_WIDTH    = grayscale_stream_pkg::CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 in_rd_en,
    input  logic                 in_empty,
    input  logic [23:0]          in_dout,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [7:0]           out_din,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] pixel_count
);
    import grayscale_stream_pkg::*;

    localparam logic [CNT_WIDTH-1:0] FP_C = CNT_WIDTH'(FRAME_PIXELS);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 s1_v, s2_v;
    logic [9:0]           s1_sum;
    logic [7:0]           s2_gray;
    logic [7:0]           div_q;
    logic                 s1_acc, s2_acc;
    rgb_t                 px;

    assign px = rgb_t'(in_dout);

    // Ready chain runs back from the output FIFO so a full pipe still moves at one pixel per cycle.
    assign out_wr_en  = s2_v & ~out_full;
    assign s2_acc     = ~s2_v | out_wr_en;
    assign s1_acc     = ~s1_v | s2_acc;
    assign in_rd_en   = (state == RUN) & ~in_empty & (rd_cnt < FP_C) & s1_acc;
    assign out_din    = s2_gray;
    assign frame_done = (state == DONE);

    gray_div3 u_div (
        .sum  (s1_sum),
        .quot (div_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_sum  <= '0;
            s2_gray <= '0;
        end else begin
            if (s1_acc) begin
                s1_v <= in_rd_en;
                if (in_rd_en) s1_sum <= rgb_sum(px);
            end
            if (s2_acc) begin
                s2_v <= s1_v;
                if (s1_v) s2_gray <= div_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt      <= '0;
            pixel_count <= '0;
        end else if (state == DONE) begin
            rd_cnt      <= '0;
            pixel_count <= '0;
        end else begin
            if (in_rd_en)  rd_cnt      <= rd_cnt + 1'b1;
            if (out_wr_en) pixel_count <= pixel_count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!in_empty) state_nxt = RUN;
            RUN:     if (rd_cnt == FP_C) state_nxt = DRAIN;
            DRAIN:   if (pixel_count == FP_C) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_grayscale_stream.sv
// Bench for grayscale_stream: divider sweep, single-pixel frame, full-rate, backpressure, random and reset-abort frames.
module tb_grayscale_stream;
    import grayscale_stream_pkg::*;

    localparam int FP = 16;
    localparam int CW = 19;

    logic          clock = 1'b0;
    logic          reset;
    always #5 clock = ~clock;

    logic          in_rd_en, in_empty, out_wr_en, out_full, frame_done;
    logic [23:0]   in_dout;
    logic [7:0]    out_din;
    logic [CW-1:0] pixel_count;

    logic          in_rd_en1, in_empty1, out_wr_en1, out_full1, frame_done1;
    logic [23:0]   in_dout1;
    logic [7:0]    out_din1;
    logic [CW-1:0] pixel_count1;

    logic [9:0]    div_sum;
    logic [7:0]    div_quot;

    grayscale_stream #(.FRAME_PIXELS(FP), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
        .frame_done(frame_done), .pixel_count(pixel_count));

    grayscale_stream #(.FRAME_PIXELS(1), .CNT_WIDTH(CW)) dut1 (
        .clock(clock), .reset(reset), .in_rd_en(in_rd_en1), .in_empty(in_empty1), .in_dout(in_dout1),
        .out_wr_en(out_wr_en1), .out_full(out_full1), .out_din(out_din1),
        .frame_done(frame_done1), .pixel_count(pixel_count1));

    gray_div3 u_div_tb (.sum(div_sum), .quot(div_quot));

    typedef struct { logic [9:0] sum; logic [7:0] q; } dv_t;
    typedef struct { logic [23:0] px; logic [7:0] g; } pv_t;

    int checks = 0, errors = 0;
    logic [23:0] src_q[$];
    logic [7:0]  exp_q[$];
    int  empty_pct = 0, full_pct = 0;
    bit  force_full = 0;
    int  pops = 0, pushes = 0, dones = 0, cyc = 0, pc_model = 0;
    int  first_wr = -1, last_wr = -1;
    bit  s_rd, s_wr, s_done, prev_done = 0;
    logic [7:0] s_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
        return 8'(s / 3);
    endfunction

    task automatic push_px(input logic [23:0] p, input logic [7:0] e);
        src_q.push_back(p);
        exp_q.push_back(e);
    endtask

    // One clock of the streaming harness; entered and left at posedge+1.
    task automatic step();
        in_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < empty_pct);
        in_dout  = (src_q.size() != 0) ? src_q[0] : 24'h0;
        out_full = force_full || (int'($urandom_range(99)) < full_pct);
        @(negedge clock);
        s_rd = in_rd_en; s_wr = out_wr_en; s_dout = out_din; s_done = frame_done;
        chk("pixel_count", 32'(pixel_count), pc_model);
        if (prev_done) chk("no_pop_after_done", 32'(in_rd_en), 0);
        if (s_rd) begin
            pops++;
            chk("pop_while_empty", 32'(in_empty), 0);
        end
        if (s_wr) begin
            pushes++;
            pc_model++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            chk("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("out_din", 32'(s_dout), 32'(exp_q.pop_front()));
        end
        if (s_done) begin
            dones++;
            chk("done_at_frame_end", pc_model, FP);
            pc_model = 0;
        end
        prev_done = s_done;
        cyc++;
        @(posedge clock);
        #1;
        if (s_rd) void'(src_q.pop_front());
    endtask

    task automatic run_frame(input int bound);
        int d0;
        int k;
        d0 = dones;
        k = 0;
        while (dones == d0 && k < bound) begin
            step();
            k++;
        end
        chk("frame_completes", 32'(dones > d0), 1);
    endtask

    dv_t dtab[6];
    pv_t ptab[8];

    initial begin
        int p0, d0, k, hold_pops, rdc, wrc, n_rd, n_done;
        logic [7:0] held, w_val;
        bit rd_now;

        dtab[0] = '{10'd765, 8'd255}; dtab[1] = '{10'd764, 8'd254};
        dtab[2] = '{10'd2, 8'd0};     dtab[3] = '{10'd3, 8'd1};
        dtab[4] = '{10'd0, 8'd0};     dtab[5] = '{10'd180, 8'd60};
        ptab[0] = '{24'h1E3C5A, 8'd60};  ptab[1] = '{24'hFFFFFF, 8'd255};
        ptab[2] = '{24'h000000, 8'd0};   ptab[3] = '{24'h010101, 8'd1};
        ptab[4] = '{24'h000002, 8'd0};   ptab[5] = '{24'hFF0000, 8'd85};
        ptab[6] = '{24'h00FFFE, 8'd169}; ptab[7] = '{24'h123456, 8'd52};

        reset = 1'b1;
        in_empty = 1'b1; in_dout = '0; out_full = 1'b0;
        in_empty1 = 1'b1; in_dout1 = '0; out_full1 = 1'b0;
        div_sum = '0;

        @(negedge clock);
        chk("rst_in_rd_en", 32'(in_rd_en), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_out_din", 32'(out_din), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_pixel_count", 32'(pixel_count), 0);
        chk("rst1_out_wr_en", 32'(out_wr_en1), 0);
        chk("rst1_pixel_count", 32'(pixel_count1), 0);

        foreach (dtab[i]) begin
            div_sum = dtab[i].sum;
            #1;
            chk($sformatf("div3_tab_%0d", dtab[i].sum), 32'(div_quot), 32'(dtab[i].q));
        end
        for (int s = 0; s <= 765; s++) begin
            div_sum = 10'(s);
            #1;
            chk("div3_sweep", 32'(div_quot), s / 3);
        end

        @(posedge clock); #1;
        reset = 1'b0;

        // Single-pixel frame on the FRAME_PIXELS=1 instance.
        in_empty1 = 1'b0; in_dout1 = 24'h1E3C5A;
        rdc = -1; wrc = -1; n_rd = 0; n_done = 0; w_val = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            rd_now = in_rd_en1;
            if (rd_now) begin n_rd++; rdc = c; end
            if (out_wr_en1) begin wrc = c; w_val = out_din1; end
            if (frame_done1) begin
                n_done++;
                chk("single_pc_at_done", 32'(pixel_count1), 1);
            end
            @(posedge clock); #1;
            if (rd_now) in_empty1 = 1'b1;
        end
        chk("single_latency", 32'(wrc - rdc), 2);
        chk("single_dout", 32'(w_val), 60);
        chk("single_pops", n_rd, 1);
        chk("single_done", n_done, 1);
        chk("single_idle", 32'(dut1.state == IDLE), 1);

        // Full-rate frame plus one spare pixel that must stay queued.
        foreach (ptab[i]) push_px(ptab[i].px, ptab[i].g);
        for (int i = 0; i < 9; i++) begin
            logic [23:0] p;
            p = 24'($urandom());
            push_px(p, ref_gray(p));
        end
        p0 = pushes; first_wr = -1;
        run_frame(200);
        chk("fullrate_writes", pushes - p0, FP);
        chk("fullrate_consecutive", 32'(last_wr - first_wr), FP - 1);
        chk("fullrate_pops", pops, FP);
        chk("fullrate_spare_left", 32'(src_q.size()), 1);

        // Backpressure mid-stream.
        for (int i = 0; i < FP - 1; i++) begin
            logic [23:0] p;
            p = 24'($urandom());
            push_px(p, ref_gray(p));
        end
        p0 = pushes; k = 0;
        while (pushes - p0 < 4 && k < 100) begin step(); k++; end
        force_full = 1; hold_pops = 0; held = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) held = s_dout;
            else chk("hold_dout_stable", 32'(s_dout), 32'(held));
            chk("hold_no_write", 32'(s_wr), 0);
            hold_pops += int'(s_rd);
        end
        chk("hold_pops_le2", 32'(hold_pops <= 2), 1);
        force_full = 0;
        run_frame(300);
        chk("bp_writes", pushes - p0, FP);
        chk("bp_queue_drained", 32'(exp_q.size()), 0);

        // Random empty/full toggling over four back-to-back frames.
        empty_pct = 30; full_pct = 30;
        for (int i = 0; i < 4 * FP; i++) begin
            logic [23:0] p;
            p = 24'($urandom());
            push_px(p, ref_gray(p));
        end
        d0 = dones; p0 = pushes; k = 0;
        while (dones - d0 < 4 && k < 4000) begin step(); k++; end
        chk("rand_frames", dones - d0, 4);
        chk("rand_writes", pushes - p0, 4 * FP);
        chk("rand_exp_empty", 32'(exp_q.size()), 0);
        chk("rand_src_empty", 32'(src_q.size()), 0);

        // Reset mid-frame, then a fresh frame from pixel 0.
        empty_pct = 0; full_pct = 0;
        for (int i = 0; i < FP; i++) begin
            logic [23:0] p;
            p = 24'($urandom());
            push_px(p, ref_gray(p));
        end
        p0 = pushes; k = 0;
        while (pushes - p0 < 5 && k < 100) begin step(); k++; end
        #2 reset = 1'b1;
        #1;
        chk("arst_in_rd_en", 32'(in_rd_en), 0);
        chk("arst_out_wr_en", 32'(out_wr_en), 0);
        chk("arst_out_din", 32'(out_din), 0);
        chk("arst_frame_done", 32'(frame_done), 0);
        chk("arst_pixel_count", 32'(pixel_count), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        src_q.delete(); exp_q.delete();
        pc_model = 0; prev_done = 0;
        for (int i = 0; i < FP; i++) begin
            logic [23:0] p;
            p = 24'($urandom());
            push_px(p, ref_gray(p));
        end
        p0 = pushes; d0 = dones;
        run_frame(300);
        chk("post_reset_writes", pushes - p0, FP);
        chk("post_reset_done_once", dones - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
